ssm_state_scan: RTL

- Consumes the joined (lambda, x_t) tile stream from the lambda/x_t join stage and performs the elementwise linear recurrence h_t = lambda * h_{t-1} + x_t.
- Holds the hidden state for every channel tile of one timestep.
- Emits updated h tiles downstream over a valid/ready stream with 1-cycle latency.
- Channels are processed as NUM_TILES consecutive tiles per timestep, in fixed order 0..NUM_TILES-1.

---
 rtl/ssm_state_scan.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ssm_state_scan.sv
// ssm_state_scan
// ----------------------------------------------------------------------------
// Elementwise linear-recurrence scan for a state-space-model layer:
//   h_t[c] = lambda[c] * h_{t-1}[c] + x_t[c]
// One timestep is presented as NUM_TILES consecutive tiles (tile 0 first).
// Each tile holds TILE_SIZE signed Q(FRAC_BITS) elements. The hidden state
// for every tile of the timestep is held internally. Updated h tiles leave
// through a single output register stage, so they appear one cycle after
// acceptance.
//
// Build option:
//   SSM_SCAN_ROUND_EN  defined   -> the scaled product is rounded half-up
//                                   before x_t is added
//                      undefined -> plain arithmetic-shift truncation
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous restart: zeros state, tile and step count,
//                     and drops any pending output
//   in_valid/in_ready joined (lambda, x_t) tile handshake
//   lam_vec, xt_vec   lambda and x_t tiles (TILE_SIZE x DATA_WIDTH, signed)
//   out_valid/ready   h tile handshake
//   h_vec             updated state tile
//   out_tile_idx      tile index of h_vec inside its timestep
//   out_last          h_vec is the final tile of its timestep
//   out_step          timestep index of h_vec
// ----------------------------------------------------------------------------
module ssm_state_scan #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int NUM_TILES  = 4,
  parameter int STEP_W     = 16,
  localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  lam_vec,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  xt_vec,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  h_vec,
  output logic [IDX_W-1:0]                      out_tile_idx,
  output logic                                  out_last,
  output logic [STEP_W-1:0]                     out_step
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  // One guard bit above the product keeps the rounding bias and the x_t
  // addition free of overflow for every input combination.
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    (SUM_W'(1) <<< (DATA_WIDTH - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

`ifdef SSM_SCAN_ROUND_EN
  localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(1) <<< (FRAC_BITS - 1);
`else
  localparam logic signed [SUM_W-1:0] RND_BIAS = '0;
`endif

  // Registered state
  logic [NUM_TILES-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] state_q, state_d;
  logic [IDX_W-1:0]                                    tile_q, tile_d;
  logic [STEP_W-1:0]                                   step_q, step_d;
  logic                                                out_valid_q, out_valid_d;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]                h_vec_q, h_vec_d;
  logic [IDX_W-1:0]                                    out_tile_idx_q, out_tile_idx_d;
  logic                                                out_last_q, out_last_d;
  logic [STEP_W-1:0]                                   out_step_q, out_step_d;

  // Datapath intermediates
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] cur_tile;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] h_new;
  logic signed [PROD_W-1:0]             lam_ext  [TILE_SIZE];
  logic signed [PROD_W-1:0]             hold_ext [TILE_SIZE];
  logic signed [PROD_W-1:0]             prod     [TILE_SIZE];
  logic signed [SUM_W-1:0]              prod_b   [TILE_SIZE];
  logic signed [SUM_W-1:0]              scaled   [TILE_SIZE];
  logic signed [SUM_W-1:0]              xt_ext   [TILE_SIZE];
  logic signed [SUM_W-1:0]              sum      [TILE_SIZE];

  logic accept;
  logic last_tile;

  assign in_ready  = !clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_tile = (tile_q == IDX_W'(NUM_TILES - 1));

  // Explicit mux instead of a direct array index keeps the select legal for
  // tile counts that are not a power of two (and for a single tile).
  always_comb begin : tile_read
    cur_tile = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (tile_q == IDX_W'(t)) begin
        cur_tile = state_q[t];
      end
    end
  end

  always_comb begin : recurrence
    for (int i = 0; i < TILE_SIZE; i++) begin
      lam_ext[i]  = {{DATA_WIDTH{lam_vec[i][DATA_WIDTH-1]}}, lam_vec[i]};
      hold_ext[i] = {{DATA_WIDTH{cur_tile[i][DATA_WIDTH-1]}}, cur_tile[i]};
      // Full-width product: |lam*h| <= 2^(2*DATA_WIDTH-2), fits in PROD_W.
      prod[i]     = lam_ext[i] * hold_ext[i];
      prod_b[i]   = {prod[i][PROD_W-1], prod[i]} + RND_BIAS;
      scaled[i]   = prod_b[i] >>> FRAC_BITS;
      xt_ext[i]   = {{(SUM_W - DATA_WIDTH){xt_vec[i][DATA_WIDTH-1]}}, xt_vec[i]};
      sum[i]      = scaled[i] + xt_ext[i];
      if (sum[i] > SAT_MAX) begin
        h_new[i] = SAT_MAX[DATA_WIDTH-1:0];
      end else if (sum[i] < SAT_MIN) begin
        h_new[i] = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
        h_new[i] = sum[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    tile_d         = tile_q;
    step_d         = step_q;
    out_valid_d    = out_valid_q;
    h_vec_d        = h_vec_q;
    out_tile_idx_d = out_tile_idx_q;
    out_last_d     = out_last_q;
    out_step_d     = out_step_q;

    if (clear) begin
      state_d     = '0;
      tile_d      = '0;
      step_d      = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (tile_q == IDX_W'(t)) begin
          state_d[t] = h_new;
        end
      end
      h_vec_d        = h_new;
      out_tile_idx_d = tile_q;
      out_last_d     = last_tile;
      out_step_d     = step_q;
      out_valid_d    = 1'b1;
      if (last_tile) begin
        tile_d = '0;
        step_d = step_q + 1'b1;
      end else begin
        tile_d = tile_q + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= '0;
      tile_q         <= '0;
      step_q         <= '0;
      out_valid_q    <= 1'b0;
      h_vec_q        <= '0;
      out_tile_idx_q <= '0;
      out_last_q     <= 1'b0;
      out_step_q     <= '0;
    end else begin
      state_q        <= state_d;
      tile_q         <= tile_d;
      step_q         <= step_d;
      out_valid_q    <= out_valid_d;
      h_vec_q        <= h_vec_d;
      out_tile_idx_q <= out_tile_idx_d;
      out_last_q     <= out_last_d;
      out_step_q     <= out_step_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign h_vec        = h_vec_q;
  assign out_tile_idx = out_tile_idx_q;
  assign out_last     = out_last_q;
  assign out_step     = out_step_q;

endmodule
